// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with an integrated busy scoreboard.
//   - NREAD combinational read ports (rd/rbusy), optional same-cycle write-through bypass
//   - one synchronous write port (we/wa/wd); write-back also clears the busy bit of wa
//   - issue port (iss_v/iss_wa) marks a destination busy; flush clears every busy bit
//   - busy_cnt is the registered popcount of the busy bits
//   - optional hardwired zero register (reads 0, ignores writes, never busy)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ra[NREAD*RWIDTH]      packed read addresses, port i at ra[i*RWIDTH +: RWIDTH]
//   rd[NREAD*DWIDTH]      packed read data,      port i at rd[i*DWIDTH +: DWIDTH]
//   rbusy[NREAD]          busy bit of the register addressed by each read port
//   we, wa, wd            write port
//   iss_v, iss_wa         issue: mark iss_wa busy
//   flush                 clear all busy bits
//   busy_cnt[RWIDTH+1]    number of busy registers
module regfile_scoreboard #(
    parameter int DWIDTH   = 32,
    parameter int RWIDTH   = 6,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREAD*RWIDTH-1:0]   ra,
    output logic [NREAD*DWIDTH-1:0]   rd,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      we,
    input  logic [RWIDTH-1:0]         wa,
    input  logic [DWIDTH-1:0]         wd,
    input  logic                      iss_v,
    input  logic [RWIDTH-1:0]         iss_wa,
    input  logic                      flush,
    output logic [RWIDTH:0]           busy_cnt
);

    localparam int DEPTH = 1 << RWIDTH;

    logic [DEPTH-1:0][DWIDTH-1:0] regs;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busy_nxt;
    logic [RWIDTH:0]              cnt_nxt;
    logic                         wr_ok;

    // Writes to the zero register are dropped so regs[0] stays 0.
    assign wr_ok = we && !((ZERO_REG != 0) && (wa == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    // Busy next state. Issue is applied after the write-back clear so a new
    // producer on the same register wins; flush overrides both.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (we)
                busy_nxt[wa] = 1'b0;
            if (iss_v)
                busy_nxt[iss_wa] = 1'b1;
        end
        if (ZERO_REG != 0)
            busy_nxt[0] = 1'b0;
    end

    // Counting the next-state bits keeps busy_cnt aligned with busy on the same edge.
    always_comb begin
        cnt_nxt = '0;
        for (int j = 0; j < DEPTH; j++)
            cnt_nxt = cnt_nxt + {{RWIDTH{1'b0}}, busy_nxt[j]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Read ports. Bypass forwards wd only; the busy bit is not bypassed, so a
    // reader in the write-back cycle still sees busy=1. Bypass is gated by
    // rst_n so reads show the cleared state while reset is held.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [RWIDTH-1:0] addr;
        logic              is_zero;
        logic              hit;

        assign addr    = ra[i*RWIDTH +: RWIDTH];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = (BYPASS != 0) && rst_n && we && (wa == addr) && !is_zero;

        assign rd[i*DWIDTH +: DWIDTH] = is_zero ? '0 : (hit ? wd : regs[addr]);
        assign rbusy[i]               = is_zero ? 1'b0 : busy[addr];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Two instances share every input:
// dut_b with BYPASS=1 and dut_n with BYPASS=0; all other parameters default.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int RW = 6;
    localparam int NR = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR*RW-1:0]   ra;
    logic               we;
    logic [RW-1:0]      wa;
    logic [DW-1:0]      wd;
    logic               iss_v;
    logic [RW-1:0]      iss_wa;
    logic               flush;

    logic [NR*DW-1:0]   rd_b, rd_n;
    logic [NR-1:0]      rbusy_b, rbusy_n;
    logic [RW:0]        cnt_b, cnt_n;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard #(.DWIDTH(DW), .RWIDTH(RW), .NREAD(NR), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_wa(iss_wa),
        .flush(flush), .busy_cnt(cnt_b)
    );

    regfile_scoreboard #(.DWIDTH(DW), .RWIDTH(RW), .NREAD(NR), .BYPASS(0), .ZERO_REG(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_wa(iss_wa),
        .flush(flush), .busy_cnt(cnt_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_wa = '0; flush = 1'b0;
    endtask

    task automatic set_ra(input logic [RW-1:0] a0, input logic [RW-1:0] a1);
        ra = {a1, a0};
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        idle();
        set_ra(0, 0);
        #12 rst_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            set_ra(a[RW-1:0], a[RW-1:0]);
            #1;
            checks++;
            if (rd_b !== '0 || rbusy_b !== '0 || rd_n !== '0 || rbusy_n !== '0) begin
                failures++; bad++;
                if (bad < 4)
                    $display("FAIL reset_read addr=%0d rd=%h rbusy=%b want 0/0", a, rd_b, rbusy_b);
            end
        end
        checks++;
        if (cnt_b !== 0 || cnt_n !== 0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d want 0", cnt_b, cnt_n);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 6'd40; wd = 32'habcdef12;
        set_ra(6'd40, 6'd1);
        #1;
        checks++;
        if (rd_b[31:0] !== 32'habcdef12) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h want abcdef12", rd_b[31:0]);
        end
        checks++;
        if (rd_n[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL nobypass_same_cycle got=%h want 00000000", rd_n[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_n[31:0] !== 32'habcdef12 || rd_b[31:0] !== 32'habcdef12) begin
            failures++;
            $display("FAIL write_next_cycle got=%h/%h want abcdef12", rd_n[31:0], rd_b[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wa = 6'd0; wd = 32'hffffffff;
        set_ra(6'd40, 6'd0);
        #1;
        checks++;
        if (rd_b[63:32] !== 32'h0) begin
            failures++;
            $display("FAIL zero_bypass got=%h want 00000000", rd_b[63:32]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_b[63:32] !== 32'h0 || rd_n[63:32] !== 32'h0) begin
            failures++;
            $display("FAIL zero_write got=%h/%h want 00000000", rd_b[63:32], rd_n[63:32]);
        end
        iss_v = 1'b1; iss_wa = 6'd0;
        tick();
        idle();
        #1;
        checks++;
        if (cnt_b !== 0 || rbusy_b[1] !== 1'b0) begin
            failures++;
            $display("FAIL zero_issue cnt=%0d rbusy=%b want 0/0", cnt_b, rbusy_b[1]);
        end
    endtask

    task automatic test_busy();
        iss_v = 1'b1; iss_wa = 6'd5;
        tick();
        checks++;
        if (cnt_b !== 1) begin
            failures++;
            $display("FAIL busy_cnt_1 got=%0d want 1", cnt_b);
        end
        iss_wa = 6'd7;
        tick();
        idle();
        set_ra(6'd5, 6'd7);
        #1;
        checks++;
        if (cnt_b !== 2) begin
            failures++;
            $display("FAIL busy_cnt_2 got=%0d want 2", cnt_b);
        end
        checks++;
        if (rbusy_b !== 2'b11) begin
            failures++;
            $display("FAIL rbusy_5_7 got=%b want 11", rbusy_b);
        end
        // Write-back cycle: data bypassed, busy still visible
        we = 1'b1; wa = 6'd5; wd = 32'h00c0ffee;
        #1;
        checks++;
        if (rbusy_b[0] !== 1'b1 || rd_b[31:0] !== 32'h00c0ffee) begin
            failures++;
            $display("FAIL wb_cycle rbusy=%b rd=%h want 1/00c0ffee", rbusy_b[0], rd_b[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (cnt_b !== 1 || rbusy_b !== 2'b10) begin
            failures++;
            $display("FAIL busy_clear cnt=%0d rbusy=%b want 1/10", cnt_b, rbusy_b);
        end
    endtask

    task automatic test_same_edge_flush();
        iss_v = 1'b1; iss_wa = 6'd9; we = 1'b1; wa = 6'd9; wd = 32'h12345678;
        tick();
        idle();
        set_ra(6'd9, 6'd7);
        #1;
        checks++;
        if (rd_b[31:0] !== 32'h12345678 || rbusy_b[0] !== 1'b1) begin
            failures++;
            $display("FAIL same_edge rd=%h rbusy=%b want 12345678/1", rd_b[31:0], rbusy_b[0]);
        end
        checks++;
        if (cnt_b !== 2) begin
            failures++;
            $display("FAIL same_edge_cnt got=%0d want 2", cnt_b);
        end
        // Flush wins over issue; write data still stored
        flush = 1'b1; iss_v = 1'b1; iss_wa = 6'd3; we = 1'b1; wa = 6'd20; wd = 32'h0badf00d;
        tick();
        idle();
        set_ra(6'd3, 6'd9);
        #1;
        checks++;
        if (cnt_b !== 0 || rbusy_b !== 2'b00 || cnt_n !== 0) begin
            failures++;
            $display("FAIL flush cnt=%0d rbusy=%b want 0/00", cnt_b, rbusy_b);
        end
        set_ra(6'd20, 6'd7);
        #1;
        checks++;
        if (rd_n[31:0] !== 32'h0badf00d || rbusy_b[1] !== 1'b0) begin
            failures++;
            $display("FAIL flush_write rd=%h rbusy7=%b want 0badf00d/0", rd_n[31:0], rbusy_b[1]);
        end
    endtask

    task automatic test_async_reset();
        we = 1'b1; wa = 6'd12; wd = 32'h5a5a5a5a; iss_v = 1'b1; iss_wa = 6'd12;
        tick();
        idle();
        set_ra(6'd12, 6'd12);
        #1;
        checks++;
        if (rd_n !== {2{32'h5a5a5a5a}} || rbusy_b !== 2'b11 || cnt_b !== 1) begin
            failures++;
            $display("FAIL pre_reset rd=%h rbusy=%b cnt=%0d", rd_n, rbusy_b, cnt_b);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_b !== '0 || rd_n !== '0 || rbusy_b !== '0 || cnt_b !== 0 || cnt_n !== 0) begin
            failures++;
            $display("FAIL async_reset rd=%h rbusy=%b cnt=%0d want 0/00/0", rd_b, rbusy_b, cnt_b);
        end
        // Inputs ignored while reset held, including the bypass path
        we = 1'b1; wa = 6'd12; wd = 32'hffffffff; iss_v = 1'b1; iss_wa = 6'd12;
        #1;
        checks++;
        if (rd_b[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL reset_bypass got=%h want 00000000", rd_b[31:0]);
        end
        tick();
        idle();
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (rd_b[31:0] !== 32'h0 || cnt_b !== 0) begin
            failures++;
            $display("FAIL reset_ignores_we rd=%h cnt=%0d want 0/0", rd_b[31:0], cnt_b);
        end
        we = 1'b1; wa = 6'd12; wd = 32'h00000001; iss_v = 1'b1; iss_wa = 6'd33;
        tick();
        idle();
        #1;
        checks++;
        if (rd_n[31:0] !== 32'h1 || cnt_b !== 1) begin
            failures++;
            $display("FAIL post_reset rd=%h cnt=%0d want 00000001/1", rd_n[31:0], cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_busy();
        test_same_edge_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
